matrix_bank_mem: RTL and testbench
==================================

Name: matrix_bank_mem

Overview:
Parametrised multi-matrix register-file memory for the matrix datapath. Generalises the fixed 8-bit, 3x3 matrix store to NUM_MAT matrices of ROWS x COLS elements, each DATA_W bits wide.
- Random-access host port with registered read and valid flag.
- Out-of-range address checking.
- Stream engine: scans one whole matrix in row-major or transposed order over a valid/ready handshake, feeding the multiplier/adder stages.

Parameters:
DATA_W, 8, element width in bits
NUM_MAT, 4, number of matrices
ROWS, 3, rows per matrix
COLS, 3, columns per matrix
MS_W = clog2(NUM_MAT), R_W = clog2(ROWS), C_W = clog2(COLS): derived localparams, each with a minimum of 1

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
matrix_select  in  MS_W  host matrix index
row  in  R_W  host row index
col  in  C_W  host column index
write_enable  in  1  host write strobe
write_data  in  DATA_W  host write data
read_enable  in  1  host read strobe
read_data  out  DATA_W  registered host read data
read_valid  out  1  read_data valid, one-cycle pulse
addr_err  out  1  one-cycle pulse on an out-of-range access
stream_start  in  1  start a matrix scan
stream_mat  in  MS_W  matrix to scan
stream_transpose  in  1  0 = row-major order, 1 = column-major order
stream_data  out  DATA_W  element being streamed
stream_valid  out  1  stream_data valid
stream_ready  in  1  consumer accepts stream_data
stream_last  out  1  marks the final element of the scan
stream_busy  out  1  engine not idle
stream_done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (asynchronous): all outputs 0; all memory elements 0; FSM returns to IDLE; scan counters 0. Reset mid-scan aborts the scan with no done pulse.
- Host write: when write_enable is high and the address is in range, mem[matrix_select][row][col] <= write_data at the clock edge.
- Host read:
  - When read_enable is high, read_data and read_valid are updated at the next edge (latency 1).
  - read_data holds its value until the next read.
  - An out-of-range read returns 0 with read_valid = 1.
- Out-of-range: row >= ROWS, col >= COLS, or matrix_select >= NUM_MAT.
  - A write is ignored.
  - addr_err pulses on the cycle after any out-of-range access (read or write).
- Simultaneous read and write to the same address: the read returns the old value (read-before-write).
- Stream FSM states:
  - IDLE: on stream_start, latch stream_mat and stream_transpose, reset the row/col counters, go to LOAD.
  - LOAD: register the element at the counters into stream_data, set stream_valid = 1, go to SEND.
  - SEND: hold stream_data and stream_valid stable while stream_ready is low.
    - On valid & ready with elements remaining: advance the counters; the next element appears in the same edge (no bubble), staying in SEND.
    - On valid & ready with stream_last = 1: clear stream_valid, pulse stream_done, go to IDLE.
- Scan order:
  - Row-major: col increments and wraps at COLS-1, then row increments.
  - Transpose: row increments first and wraps at ROWS-1, then col increments.
- stream_last is high exactly while the final element (ROWS-1, COLS-1) is presented.
- stream_busy = 1 in LOAD and SEND.
- stream_start while busy is ignored.
- stream_mat >= NUM_MAT at start: no scan; addr_err pulses; stream_done pulses the next cycle.
- Timing: scan start at edge N gives first valid at N+2. With ready held high, the full scan takes ROWS*COLS cycles.
- Host writes during a scan are allowed. The stream shows each element's value at the time it is read out.

Optional Feature:
MATRIX_CLEAR_EN:
- When defined, adds input clear_start (1 bit) and input clear_mat (MS_W bits), and extends stream_busy to cover clearing.
- clear_start in IDLE enters state CLEAR, which writes 0 to one element per cycle in row-major order for ROWS*COLS cycles, then pulses stream_done and returns to IDLE.
- Host writes to the matrix being cleared during CLEAR are overridden by the clear only at the element currently being cleared.
- clear_start together with stream_start: clear wins.
- When undefined: no extra ports, no CLEAR state; matrices are zeroed only by reset.

Decomposition:
- Shared package matrix_pkg:
  - DATA_W, NUM_MAT, ROWS, COLS defaults.
  - Stream FSM state enum (IDLE, LOAD, SEND, CLEAR).
  - Helper function for the in-range check.
- One sub-module, matrix_scan_ctr: row/col counter with transpose mode, wrap handling and last flag; reused for both scan and clear.

Test Plan:
1. Write 1..9 row-major to matrix 0, read each back -> read_data 1..9, read_valid one cycle after each read_enable.
2. Write to row=3 (ROWS=3) -> addr_err pulse; matrix unchanged; a read of row=3 returns 0.
3. Stream matrix 0, ready held high -> stream_data 1,2,...,9 on consecutive cycles; stream_last on 9; stream_done the cycle after.
4. Stream matrix 0 with transpose and ready toggled 1,0,1,0 -> stream_data 1,4,7,2,5,8,3,6,9; data held stable while ready is low.
5. Assert reset in the middle of a scan (after the 4th element) -> all outputs 0 asynchronously, no stream_done, memory reads 0 afterwards.
6. Under MATRIX_CLEAR_EN: clear matrix 0 after filling it -> stream_busy high for 9 cycles, then all reads return 0 and matrix 1 is unaffected.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared sizing defaults, stream FSM state codes and address helpers for the matrix bank.
// The optional clear engine is enabled by defining MATRIX_CLEAR_EN.
package matrix_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_NUM_MAT = 4;
   localparam int DEF_ROWS    = 3;
   localparam int DEF_COLS    = 3;

   // Stream FSM state codes; ST_CLEAR is only reachable when MATRIX_CLEAR_EN is defined
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_CLEAR = 2'd3;

   function automatic logic in_range(input int unsigned ms, input int unsigned r,
                                     input int unsigned c, input int unsigned nm,
                                     input int unsigned nr, input int unsigned nc);
      return (ms < nm) && (r < nr) && (c < nc);
   endfunction

   function automatic int unsigned flat_index(input int unsigned ms, input int unsigned r,
                                              input int unsigned c, input int unsigned nr,
                                              input int unsigned nc);
      return (ms * nr + r) * nc + c;
   endfunction

endpackage

// File: rtl/matrix_scan_ctr.sv
// Row/column scan counter with row-major or transposed order, exposing the current
// and the following position plus last-element flags for both.
module matrix_scan_ctr
   import matrix_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic           clk,
   input  logic           i_reset,
   input  logic           i_clear,
   input  logic           i_advance,
   input  logic           i_transpose,
   output logic [R_W-1:0] o_row,
   output logic [C_W-1:0] o_col,
   output logic [R_W-1:0] o_next_row,
   output logic [C_W-1:0] o_next_col,
   output logic           o_last,
   output logic           o_next_last
);

   localparam logic [R_W-1:0] LP_ROW_MAX = R_W'(ROWS - 1);
   localparam logic [C_W-1:0] LP_COL_MAX = C_W'(COLS - 1);

   logic [R_W-1:0] r_row;
   logic [C_W-1:0] r_col;
   logic [R_W-1:0] w_next_row;
   logic [C_W-1:0] w_next_col;

   // Both orders finish on (ROWS-1, COLS-1), so the last flag is order independent
   always_comb begin
      w_next_row = r_row;
      w_next_col = r_col;
      if (i_transpose) begin
         if (r_row == LP_ROW_MAX) begin
            w_next_row = '0;
            w_next_col = (r_col == LP_COL_MAX) ? '0 : r_col + 1'b1;
         end else begin
            w_next_row = r_row + 1'b1;
         end
      end else begin
         if (r_col == LP_COL_MAX) begin
            w_next_col = '0;
            w_next_row = (r_row == LP_ROW_MAX) ? '0 : r_row + 1'b1;
         end else begin
            w_next_col = r_col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         r_row <= w_next_row;
         r_col <= w_next_col;
      end
   end

   assign o_row       = r_row;
   assign o_col       = r_col;
   assign o_next_row  = w_next_row;
   assign o_next_col  = w_next_col;
   assign o_last      = (r_row == LP_ROW_MAX) && (r_col == LP_COL_MAX);
   assign o_next_last = (w_next_row == LP_ROW_MAX) && (w_next_col == LP_COL_MAX);

endmodule

// File: rtl/matrix_bank_mem.sv
// Multi-matrix register file with a registered host port and a valid/ready stream engine.
// Define MATRIX_CLEAR_EN to add the clear_start/clear_mat matrix-clear engine.
module matrix_bank_mem
   import matrix_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NUM_MAT = DEF_NUM_MAT,
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   localparam int MS_W   = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1,
   localparam int R_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int C_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [MS_W-1:0]   matrix_select,
   input  logic [R_W-1:0]    row,
   input  logic [C_W-1:0]    col,
   input  logic              write_enable,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_enable,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   output logic              addr_err,
   input  logic              stream_start,
   input  logic [MS_W-1:0]   stream_mat,
   input  logic              stream_transpose,
   output logic [DATA_W-1:0] stream_data,
   output logic              stream_valid,
   input  logic              stream_ready,
   output logic              stream_last,
   output logic              stream_busy,
`ifdef MATRIX_CLEAR_EN
   input  logic              clear_start,
   input  logic [MS_W-1:0]   clear_mat,
`endif
   output logic              stream_done
);

   localparam int DEPTH = NUM_MAT * ROWS * COLS;
   localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [1:0]        r_state;
   logic [MS_W-1:0]   r_mat;
   logic              r_transpose;
   logic [DATA_W-1:0] r_stream_data;
   logic              r_stream_valid;
   logic              r_stream_last;
   logic              r_stream_done;
   logic [DATA_W-1:0] r_read_data;
   logic              r_read_valid;
   logic              r_addr_err;
   logic              r_err_pending;

   logic              w_host_ok;
   logic              w_host_err;
   logic              w_stream_mat_ok;
   logic [A_W-1:0]    w_host_addr;
   logic [A_W-1:0]    w_cur_addr;
   logic [A_W-1:0]    w_next_addr;
   logic [R_W-1:0]    w_row;
   logic [C_W-1:0]    w_col;
   logic [R_W-1:0]    w_next_row;
   logic [C_W-1:0]    w_next_col;
   logic              w_last;
   logic              w_next_last;
   logic              w_ctr_clear;
   logic              w_ctr_adv;
`ifdef MATRIX_CLEAR_EN
   logic              w_clear_mat_ok;
`endif

   always_comb begin
      w_host_ok       = in_range(32'(matrix_select), 32'(row), 32'(col), NUM_MAT, ROWS, COLS);
      w_host_err      = (read_enable || write_enable) && !w_host_ok;
      w_stream_mat_ok = in_range(32'(stream_mat), 0, 0, NUM_MAT, ROWS, COLS);
      w_host_addr     = A_W'(flat_index(32'(matrix_select), 32'(row), 32'(col), ROWS, COLS));
      w_cur_addr      = A_W'(flat_index(32'(r_mat), 32'(w_row), 32'(w_col), ROWS, COLS));
      w_next_addr     = A_W'(flat_index(32'(r_mat), 32'(w_next_row), 32'(w_next_col), ROWS, COLS));
   end

`ifdef MATRIX_CLEAR_EN
   assign w_clear_mat_ok = in_range(32'(clear_mat), 0, 0, NUM_MAT, ROWS, COLS);
   assign w_ctr_adv = ((r_state == ST_SEND) && stream_ready && !r_stream_last) ||
                      ((r_state == ST_CLEAR) && !w_last);
`else
   assign w_ctr_adv = (r_state == ST_SEND) && stream_ready && !r_stream_last;
`endif
   // Counters sit at (0,0) whenever idle, so LOAD always starts from the first element
   assign w_ctr_clear = (r_state == ST_IDLE);

   matrix_scan_ctr #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_scan_ctr (
      .clk         (clk),
      .i_reset     (reset),
      .i_clear     (w_ctr_clear),
      .i_advance   (w_ctr_adv),
      .i_transpose (r_transpose),
      .o_row       (w_row),
      .o_col       (w_col),
      .o_next_row  (w_next_row),
      .o_next_col  (w_next_col),
      .o_last      (w_last),
      .o_next_last (w_next_last)
   );

   // Storage and host port; NBA ordering makes same-address reads return the old value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_read_data  <= '0;
         r_read_valid <= 1'b0;
      end else begin
         r_read_valid <= read_enable;
         if (read_enable) begin
            r_read_data <= w_host_ok ? r_mem[w_host_addr] : '0;
         end
         if (write_enable && w_host_ok) begin
            r_mem[w_host_addr] <= write_data;
         end
`ifdef MATRIX_CLEAR_EN
         // Placed after the host write so the clear wins only on the element being cleared
         if (r_state == ST_CLEAR) begin
            r_mem[w_cur_addr] <= '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_mat          <= '0;
         r_transpose    <= 1'b0;
         r_stream_data  <= '0;
         r_stream_valid <= 1'b0;
         r_stream_last  <= 1'b0;
         r_stream_done  <= 1'b0;
         r_addr_err     <= 1'b0;
         r_err_pending  <= 1'b0;
      end else begin
         r_stream_done <= 1'b0;
         r_addr_err    <= w_host_err;
         r_err_pending <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_err_pending) begin
                  r_stream_done <= 1'b1;
`ifdef MATRIX_CLEAR_EN
               end else if (clear_start) begin
                  if (w_clear_mat_ok) begin
                     r_mat       <= clear_mat;
                     r_transpose <= 1'b0;
                     r_state     <= ST_CLEAR;
                  end else begin
                     r_addr_err    <= 1'b1;
                     r_err_pending <= 1'b1;
                  end
`endif
               end else if (stream_start) begin
                  if (w_stream_mat_ok) begin
                     r_mat       <= stream_mat;
                     r_transpose <= stream_transpose;
                     r_state     <= ST_LOAD;
                  end else begin
                     r_addr_err    <= 1'b1;
                     r_err_pending <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               r_stream_data  <= r_mem[w_cur_addr];
               r_stream_valid <= 1'b1;
               r_stream_last  <= w_last;
               r_state        <= ST_SEND;
            end
            ST_SEND: begin
               if (stream_ready) begin
                  if (r_stream_last) begin
                     r_stream_valid <= 1'b0;
                     r_stream_last  <= 1'b0;
                     r_stream_done  <= 1'b1;
                     r_state        <= ST_IDLE;
                  end else begin
                     r_stream_data <= r_mem[w_next_addr];
                     r_stream_last <= w_next_last;
                  end
               end
            end
`ifdef MATRIX_CLEAR_EN
            ST_CLEAR: begin
               if (w_last) begin
                  r_stream_done <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign read_data    = r_read_data;
   assign read_valid   = r_read_valid;
   assign addr_err     = r_addr_err;
   assign stream_data  = r_stream_data;
   assign stream_valid = r_stream_valid;
   assign stream_last  = r_stream_last;
   assign stream_done  = r_stream_done;
   assign stream_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_matrix_bank_mem.sv
// Scoreboard testbench for matrix_bank_mem: host reads and stream elements are queued
// when driven and compared as the DUT produces them. Define MATRIX_CLEAR_EN for the clear test.
module tb_matrix_bank_mem;

   localparam int DW  = 8;
   localparam int NM  = 4;
   localparam int NR  = 3;
   localparam int NC  = 3;
   localparam int MSW = 2;
   localparam int RW  = 2;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [MSW-1:0] matrix_select;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   logic           write_enable;
   logic [DW-1:0]  write_data;
   logic           read_enable;
   logic [DW-1:0]  read_data;
   logic           read_valid;
   logic           addr_err;
   logic           stream_start;
   logic [MSW-1:0] stream_mat;
   logic           stream_transpose;
   logic [DW-1:0]  stream_data;
   logic           stream_valid;
   logic           stream_ready;
   logic           stream_last;
   logic           stream_busy;
   logic           stream_done;
`ifdef MATRIX_CLEAR_EN
   logic           clear_start;
   logic [MSW-1:0] clear_mat;
`endif

   always #5 clk = ~clk;

   matrix_bank_mem dut (
      .clk              (clk),
      .reset            (reset),
      .matrix_select    (matrix_select),
      .row              (row),
      .col              (col),
      .write_enable     (write_enable),
      .write_data       (write_data),
      .read_enable      (read_enable),
      .read_data        (read_data),
      .read_valid       (read_valid),
      .addr_err         (addr_err),
      .stream_start     (stream_start),
      .stream_mat       (stream_mat),
      .stream_transpose (stream_transpose),
      .stream_data      (stream_data),
      .stream_valid     (stream_valid),
      .stream_ready     (stream_ready),
      .stream_last      (stream_last),
      .stream_busy      (stream_busy),
`ifdef MATRIX_CLEAR_EN
      .clear_start      (clear_start),
      .clear_mat        (clear_mat),
`endif
      .stream_done      (stream_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   logic [DW-1:0] model [NM][NR][NC];
   logic [DW-1:0] rd_q [$];
   logic [DW-1:0] sq_data [$];
   logic          sq_last [$];
   logic [DW-1:0] last_rd;

   int   acc_cnt   = 0;
   int   done_cnt  = 0;
   int   valid_cyc = 0;
   bit   mon_done_en = 1'b1;

   logic          prev_valid, prev_ready, prev_last_acc;
   logic [DW-1:0] prev_data;

   // Output monitor: samples on the falling edge, when inputs and outputs are both settled
   always @(negedge clk) begin
      if (reset) begin
         prev_valid    = 1'b0;
         prev_ready    = 1'b0;
         prev_last_acc = 1'b0;
      end else begin
         if (read_valid) begin
            if (rd_q.size() == 0) check_eq("rd_unexpected", read_valid, 0);
            else check_eq("rd_data", read_data, rd_q.pop_front());
         end
         if (mon_done_en && (stream_done || prev_last_acc))
            check_eq("done_pulse", stream_done, prev_last_acc);
         if (stream_done) done_cnt++;
         if (stream_valid) begin
            valid_cyc++;
            if (prev_valid && !prev_ready) check_eq("hold_data", stream_data, prev_data);
            if (stream_ready) begin
               acc_cnt++;
               if (sq_data.size() == 0) begin
                  check_eq("st_unexpected", stream_valid, 0);
               end else begin
                  check_eq("st_data", stream_data, sq_data.pop_front());
                  check_eq("st_last", stream_last, sq_last.pop_front());
               end
            end
         end
         prev_valid    = stream_valid;
         prev_ready    = stream_ready;
         prev_data     = stream_data;
         prev_last_acc = stream_valid && stream_ready && stream_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input int ms, input int r, input int c, input logic [DW-1:0] d);
      bit inr;
      inr = (ms < NM) && (r < NR) && (c < NC);
      matrix_select = MSW'(ms);
      row = RW'(r);
      col = CW'(c);
      write_data = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      if (inr) model[ms][r][c] = d;
      check_eq("wr_addr_err", addr_err, {31'd0, !inr});
   endtask

   task automatic host_read(input int ms, input int r, input int c);
      bit inr;
      inr = (ms < NM) && (r < NR) && (c < NC);
      matrix_select = MSW'(ms);
      row = RW'(r);
      col = CW'(c);
      last_rd = inr ? model[ms][r][c] : '0;
      rd_q.push_back(last_rd);
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      check_eq("rd_addr_err", addr_err, {31'd0, !inr});
   endtask

   // Read and write the same address in one cycle; the read must see the old value
   task automatic host_rw(input int ms, input int r, input int c, input logic [DW-1:0] d);
      matrix_select = MSW'(ms);
      row = RW'(r);
      col = CW'(c);
      rd_q.push_back(model[ms][r][c]);
      write_data = d;
      write_enable = 1'b1;
      read_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      read_enable = 1'b0;
      model[ms][r][c] = d;
   endtask

   task automatic push_scan(input int mat, input bit tr);
      if (tr) begin
         for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
               sq_data.push_back(model[mat][r][c]);
               sq_last.push_back((r == NR - 1) && (c == NC - 1));
            end
      end else begin
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
               sq_data.push_back(model[mat][r][c]);
               sq_last.push_back((r == NR - 1) && (c == NC - 1));
            end
      end
   endtask

   task automatic run_stream(input int mat, input bit tr, input bit toggle);
      int acc_base, done_base, vc_base;
      push_scan(mat, tr);
      acc_base  = acc_cnt;
      done_base = done_cnt;
      vc_base   = valid_cyc;
      stream_mat = MSW'(mat);
      stream_transpose = tr;
      stream_ready = 1'b1;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      @(negedge clk);
      check_eq("lat_n1_valid", stream_valid, 0);
      check_eq("lat_n1_busy", stream_busy, 1);
      @(negedge clk);
      check_eq("lat_n2_valid", stream_valid, 1);
      for (int k = 0; k < 60 && done_cnt == done_base; k++) begin
         tick();
         if (toggle) stream_ready = ~stream_ready;
      end
      stream_ready = 1'b0;
      check_eq("scan_done_cnt", done_cnt - done_base, 1);
      check_eq("scan_accepted", acc_cnt - acc_base, NR * NC);
      if (!toggle) check_eq("scan_valid_cycles", valid_cyc - vc_base, NR * NC);
      check_eq("scan_busy_after", stream_busy, 0);
   endtask

   initial begin
      int base, k, busy_cnt;
      reset = 1'b1;
      matrix_select = '0; row = '0; col = '0;
      write_enable = 1'b0; write_data = '0; read_enable = 1'b0;
      stream_start = 1'b0; stream_mat = '0; stream_transpose = 1'b0; stream_ready = 1'b0;
`ifdef MATRIX_CLEAR_EN
      clear_start = 1'b0; clear_mat = '0;
`endif
      for (int m = 0; m < NM; m++)
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) model[m][r][c] = '0;
      #3;
      check_eq("reset_outputs",
               {read_data, read_valid, addr_err, stream_data, stream_valid, stream_last, stream_done}, 0);
      check_eq("reset_busy", stream_busy, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Fill matrix 0 with 1..9 and matrix 1 with distinct values, then read back
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_write(0, r, c, DW'(r * NC + c + 1));
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_write(1, r, c, DW'(8'h10 + r * NC + c));
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_read(0, r, c);
      tick();
      check_eq("rv_pulse_end", read_valid, 0);
      tick();
      check_eq("rd_hold", read_data, last_rd);

      // Read-before-write on one address, then restore
      host_rw(0, 1, 1, 8'hAA);
      host_read(0, 1, 1);
      host_write(0, 1, 1, 8'd5);

      // Out-of-range writes are dropped; out-of-range reads return 0 with valid
      host_write(0, 3, 0, 8'hEE);
      host_write(0, 0, 3, 8'hEE);
      tick();
      check_eq("err_pulse_end", addr_err, 0);
      host_read(0, 3, 0);
      host_read(1, 2, 3);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_read(0, r, c);
      tick();

      run_stream(0, 1'b0, 1'b0);
      tick();
      run_stream(0, 1'b1, 1'b1);
      tick();
      run_stream(1, 1'b1, 1'b0);
      tick();

`ifdef MATRIX_CLEAR_EN
      mon_done_en = 1'b0;
      base = done_cnt;
      busy_cnt = 0;
      clear_mat = '0;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (stream_busy) busy_cnt++;
         else if (busy_cnt > 0) break;
      end
      check_eq("clear_busy_cycles", busy_cnt, NR * NC);
      check_eq("clear_done", done_cnt - base, 1);
      mon_done_en = 1'b1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) model[0][r][c] = '0;
      tick();
      for (int m = 0; m < 2; m++)
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) host_read(m, r, c);
      tick();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_write(0, r, c, DW'(r * NC + c + 1));
`endif

      // Reset in the middle of a scan, right after the 4th element is accepted
      push_scan(0, 1'b0);
      base = acc_cnt;
      stream_mat = '0;
      stream_transpose = 1'b0;
      stream_ready = 1'b1;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      k = 0;
      while (k < 40 && (acc_cnt - base) < 4) begin
         @(posedge clk);
         #2;
         k++;
      end
      check_eq("mid_scan_reached", acc_cnt - base, 4);
      reset = 1'b1;
      #1;
      check_eq("async_rst_outputs",
               {read_data, read_valid, addr_err, stream_data, stream_valid, stream_last, stream_done}, 0);
      check_eq("async_rst_busy", stream_busy, 0);
      sq_data.delete();
      sq_last.delete();
      stream_ready = 1'b0;
      base = done_cnt;
      tick();
      tick();
      reset = 1'b0;
      for (int m = 0; m < NM; m++)
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) model[m][r][c] = '0;
      stream_ready = 1'b1;
      repeat (4) tick();
      stream_ready = 1'b0;
      check_eq("no_done_after_rst", done_cnt - base, 0);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) host_read(0, r, c);
      host_read(1, 0, 0);
      tick();
      tick();

      check_eq("rd_queue_drained", rd_q.size(), 0);
      check_eq("st_queue_drained", sq_data.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
